// File: rtl/bsg_skid_pkg.sv
// Shared types and constants for the skid buffer.
package bsg_skid_pkg;

  localparam int bsg_skid_width_gp = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } bsg_skid_state_e;

endpackage

// File: rtl/bsg_dff_en_rn.sv
// Enabled flop bank with asynchronous active-low reset to zero.
module bsg_dff_en_rn #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i)  data_o <= '0;
    else if (en_i)   data_o <= data_i;

endmodule

// File: rtl/bsg_skid_buffer_width_p3.sv
// Two-entry skid buffer: valid/ready upstream, valid/yumi downstream, ready from state only.
// Optional stall counter output enabled by BSG_SKID_BUFFER_STALL_CNT_EN.
module bsg_skid_buffer_width_p3
  import bsg_skid_pkg::*;
#(
  parameter int width_p     = bsg_skid_width_gp,
  parameter int harden_p    = 1,
  parameter int cnt_width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
  ,output logic [cnt_width_p-1:0] stall_cnt_o
`endif
);

  bsg_skid_state_e     state, state_n;
  logic                main_en, skid_en;
  logic [width_p-1:0]  main_d, skid_q;

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state <= EMPTY;
    else            state <= state_n;

  always_comb begin
    state_n = state;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = data_i;
    case (state)
      EMPTY: if (v_i) begin
        main_en = 1'b1;
        state_n = ONE;
      end
      ONE: begin
        if (v_i && yumi_i) main_en = 1'b1;
        else if (v_i) begin
          skid_en = 1'b1;
          state_n = TWO;
        end else if (yumi_i) state_n = EMPTY;
      end
      // upstream sees ready_o=0 here, so v_i is deliberately ignored
      TWO: if (yumi_i) begin
        main_en = 1'b1;
        main_d  = skid_q;
        state_n = ONE;
      end
      default: state_n = EMPTY;
    endcase
  end

  assign ready_o = (state != TWO);
  assign v_o     = (state != EMPTY);

  bsg_dff_en_rn #(.width_p(width_p)) main_reg (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (main_en),
    .data_i    (main_d),
    .data_o    (data_o)
  );

  bsg_dff_en_rn #(.width_p(width_p)) skid_reg (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (skid_en),
    .data_i    (data_i),
    .data_o    (skid_q)
  );

`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i)
      stall_cnt_o <= '0;
    else if (v_o && !yumi_i && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + cnt_width_p'(1);
`endif

  always @(posedge clk_i)
    if (reset_n_i)
      assert (!(yumi_i && !v_o))
        else $warning("illegal yumi_i with v_o=0 (harden_p=%0d cnt_width_p=%0d)",
                      harden_p, cnt_width_p);

endmodule

// File: tb/tb_bsg_skid_buffer_width_p3.sv
// Directed bench for bsg_skid_buffer_width_p3; stall counter checks under BSG_SKID_BUFFER_STALL_CNT_EN.
module tb_bsg_skid_buffer_width_p3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       v, yumi, ready, v_out;
  logic [2:0] din, dout;
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
  logic [1:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bsg_skid_buffer_width_p3 #(.width_p(3), .harden_p(1), .cnt_width_p(2)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .v_i       (v),
    .data_i    (din),
    .ready_o   (ready),
    .v_o       (v_out),
    .data_o    (dout),
    .yumi_i    (yumi)
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
    ,.stall_cnt_o (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic er, input logic [2:0] ed);
    chk({tag, ".v_o"},    32'(v_out), 32'(ev));
    chk({tag, ".ready_o"},32'(ready), 32'(er));
    chk({tag, ".data_o"}, 32'(dout),  32'(ed));
  endtask

  initial begin
    reset_n = 1'b0; v = 1'b0; yumi = 1'b0; din = 3'd0;
    #3;
    chk_out("reset", 1'b0, 1'b1, 3'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk_out("idle", 1'b0, 1'b1, 3'd0);

    // streaming 1..4 at one beat per cycle
    v = 1'b1; din = 3'd1;
    tick();
    chk_out("stream1", 1'b1, 1'b1, 3'd1);
    for (int k = 2; k <= 4; k++) begin
      din = 3'(k); yumi = 1'b1;
      tick();
      chk_out($sformatf("stream%0d", k), 1'b1, 1'b1, 3'(k));
    end
    v = 1'b0;
    tick();
    chk_out("stream_end", 1'b0, 1'b1, 3'd4);
    yumi = 1'b0;

    // backpressure 5,6,7
    v = 1'b1; din = 3'd5;
    tick();
    chk_out("bp5", 1'b1, 1'b1, 3'd5);
    din = 3'd6;
    tick();
    chk_out("bp6_full", 1'b1, 1'b0, 3'd5);
    din = 3'd7;
    tick();
    chk_out("bp7_held", 1'b1, 1'b0, 3'd5);
    yumi = 1'b1;
    tick();
    chk_out("bp_rel6", 1'b1, 1'b1, 3'd6);
    tick();
    chk_out("bp_rel7", 1'b1, 1'b1, 3'd7);
    v = 1'b0;
    tick();
    chk_out("bp_empty", 1'b0, 1'b1, 3'd7);
    yumi = 1'b0;

    // fill to TWO with 3,4 then drain
    v = 1'b1; din = 3'd3;
    tick();
    din = 3'd4;
    tick();
    chk_out("drain_full", 1'b1, 1'b0, 3'd3);
    v = 1'b0; yumi = 1'b1;
    tick();
    chk_out("drain4", 1'b1, 1'b1, 3'd4);
    tick();
    chk_out("drain_empty", 1'b0, 1'b1, 3'd4);

    // yumi while empty must not change anything
    tick();
    chk_out("illegal_yumi", 1'b0, 1'b1, 3'd4);
    yumi = 1'b0;

    // async reset while in TWO
    v = 1'b1; din = 3'd5;
    tick();
    din = 3'd6;
    tick();
    chk_out("pre_rst_two", 1'b1, 1'b0, 3'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b1, 3'd0);
    din = 3'd2;
    tick();
    chk_out("rst_ignores_in", 1'b0, 1'b1, 3'd0);
    v = 1'b0;
    reset_n = 1'b1;
    tick();
    chk_out("post_rst", 1'b0, 1'b1, 3'd0);

    v = 1'b1; din = 3'd2;
    tick();
    chk_out("post_rst_load", 1'b1, 1'b1, 3'd2);
    v = 1'b0;
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
    chk("stall0", 32'(stall_cnt), 32'd0);
    tick(); chk("stall1", 32'(stall_cnt), 32'd1);
    tick(); chk("stall2", 32'(stall_cnt), 32'd2);
    tick(); chk("stall3", 32'(stall_cnt), 32'd3);
    tick(); chk("stall_sat1", 32'(stall_cnt), 32'd3);
    tick(); chk("stall_sat2", 32'(stall_cnt), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("stall_rst", 32'(stall_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
